// File: rtl/mc_sequencer.sv
// Multicycle control sequencer that sits ahead of the register file: fetches an
// instruction over req/ack, walks it through IF/ID/EX/MEM/WB and counts retirements.
module mc_sequencer #(
   parameter int WORD_WIDTH     = 16,
   parameter int REG_ADDR_WIDTH = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   output logic                      inst_req,
   input  logic                      inst_ack,
   input  logic [WORD_WIDTH-1:0]     inst_data,
   output logic                      mem_req,
   output logic                      mem_we,
   input  logic                      mem_ack,
   output logic [REG_ADDR_WIDTH-1:0] readReg1,
   output logic [REG_ADDR_WIDTH-1:0] readReg2,
   output logic [REG_ADDR_WIDTH-1:0] writeReg,
   output logic                      RegWrite,
   output logic                      PVSWriteEn,
   output logic [3:0]                alu_op,
   output logic                      alu_src_imm,
   output logic [1:0]                wb_src,
   output logic                      out_valid,
   output logic                      halted,
   output logic [WORD_WIDTH-1:0]     num_inst
);

   typedef enum logic [2:0] {
      S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT
   } state_t;

   typedef enum logic [3:0] {
      I_RALU, I_ADI, I_ORI, I_LHI, I_LWD, I_SWD, I_BRANCH,
      I_JMP, I_JAL, I_JPR, I_JRL, I_WWD, I_HLT, I_UNDEF
   } inst_t;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_LHI = 4'd8;

   state_t                  state_q, state_d;
   logic [WORD_WIDTH-1:0]   instReg_q, instReg_d;
   logic [WORD_WIDTH-1:0]   numInst_q, numInst_d;
   logic [3:0]              opcode;
   logic [5:0]              func;
   inst_t                   instClass;

   assign opcode   = instReg_q[15:12];
   assign func     = instReg_q[5:0];
   assign readReg1 = instReg_q[11:10];
   assign readReg2 = instReg_q[9:8];
   assign num_inst = numInst_q;

   // The IR only captures on an acknowledged fetch; everything downstream decodes from it.
   assign instReg_d = (state_q == S_IF && inst_ack) ? inst_data : instReg_q;
   assign numInst_d = (state_q == S_WB) ? numInst_q + 1'b1 : numInst_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IF;
         instReg_q <= '0;
         numInst_q <= '0;
      end else begin
         state_q   <= state_d;
         instReg_q <= instReg_d;
         numInst_q <= numInst_d;
      end
   end

   always_comb begin
      instClass = I_UNDEF;
      case (opcode)
         4'd0, 4'd1, 4'd2, 4'd3: instClass = I_BRANCH;
         4'd4:  instClass = I_ADI;
         4'd5:  instClass = I_ORI;
         4'd6:  instClass = I_LHI;
         4'd7:  instClass = I_LWD;
         4'd8:  instClass = I_SWD;
         4'd9:  instClass = I_JMP;
         4'd10: instClass = I_JAL;
         4'd15: begin
            if (func < 6'd8) begin
               instClass = I_RALU;
            end else begin
               case (func)
                  6'd25:   instClass = I_JPR;
                  6'd26:   instClass = I_JRL;
                  6'd28:   instClass = I_WWD;
                  6'd29:   instClass = I_HLT;
                  default: instClass = I_UNDEF;
               endcase
            end
         end
         default: instClass = I_UNDEF;
      endcase
   end

   // R-type writes rd; linking jumps always target r2; everything else names rt.
   always_comb begin
      writeReg = instReg_q[9:8];
      if (instClass == I_RALU) begin
         writeReg = instReg_q[7:6];
      end else if (instClass == I_JAL || instClass == I_JRL) begin
         writeReg = REG_ADDR_WIDTH'(2);
      end
   end

   always_comb begin
      state_d     = state_q;
      inst_req    = 1'b0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      RegWrite    = 1'b0;
      PVSWriteEn  = 1'b0;
      alu_op      = ALU_ADD;
      alu_src_imm = 1'b0;
      wb_src      = 2'd0;
      out_valid   = 1'b0;
      halted      = 1'b0;
      case (state_q)
         S_IF: begin
            inst_req = 1'b1;
            if (inst_ack) state_d = S_ID;
         end
         S_ID: begin
            case (instClass)
               I_RALU, I_ADI, I_ORI, I_LHI, I_LWD, I_SWD, I_BRANCH: state_d = S_EX;
               I_HLT:   state_d = S_HALT;
               default: state_d = S_WB;
            endcase
         end
         S_EX: begin
            case (instClass)
               I_RALU:  alu_op = func[3:0];
               I_ORI: begin
                  alu_op      = ALU_OR;
                  alu_src_imm = 1'b1;
               end
               I_LHI: begin
                  alu_op      = ALU_LHI;
                  alu_src_imm = 1'b1;
               end
               I_BRANCH: alu_op = ALU_SUB;
               default: begin
                  alu_op      = ALU_ADD;
                  alu_src_imm = 1'b1;
               end
            endcase
            state_d = (instClass == I_LWD || instClass == I_SWD) ? S_MEM : S_WB;
         end
         S_MEM: begin
            mem_req = 1'b1;
            mem_we  = (instClass == I_SWD);
            if (mem_ack) state_d = S_WB;
         end
         S_WB: begin
            PVSWriteEn = 1'b1;
            case (instClass)
               I_RALU, I_ADI, I_ORI, I_LHI: RegWrite = 1'b1;
               I_LWD: begin
                  RegWrite = 1'b1;
                  wb_src   = 2'd1;
               end
               I_JAL, I_JRL: begin
                  RegWrite = 1'b1;
                  wb_src   = 2'd2;
               end
               I_WWD:   out_valid = 1'b1;
               default: RegWrite  = 1'b0;
            endcase
            state_d = S_IF;
         end
         S_HALT: halted = 1'b1;
         default: state_d = S_IF;
      endcase
   end

endmodule

// File: tb/tb_mc_sequencer.sv
// Bench for mc_sequencer: directed instruction stream checked every cycle against
// a latency-based behavioural model, plus literal expectations at key points.
module tb_mc_sequencer;

   logic        clk = 1'b0;
   logic        reset, inst_ack, mem_ack;
   logic [15:0] inst_data;
   logic        inst_req, mem_req, mem_we, RegWrite, PVSWriteEn;
   logic [1:0]  readReg1, readReg2, writeReg, wb_src;
   logic [3:0]  alu_op;
   logic        alu_src_imm, out_valid, halted;
   logic [15:0] num_inst;

   int testsRun = 0;
   int testsFailed = 0;
   int cycleCount = 0;
   int memReqCycles = 0;
   int memWeCycles = 0;

   mc_sequencer #(.WORD_WIDTH(16), .REG_ADDR_WIDTH(2)) dut (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_ack(inst_ack), .inst_data(inst_data),
      .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
      .readReg1(readReg1), .readReg2(readReg2), .writeReg(writeReg),
      .RegWrite(RegWrite), .PVSWriteEn(PVSWriteEn),
      .alu_op(alu_op), .alu_src_imm(alu_src_imm), .wb_src(wb_src),
      .out_valid(out_valid), .halted(halted), .num_inst(num_inst)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Instruction kinds and phases are the bench's own vocabulary, derived from the ISA rules.
   localparam int K_RALU = 0, K_ADI = 1, K_ORI = 2, K_LHI = 3, K_LWD = 4, K_SWD = 5, K_BR = 6;
   localparam int K_JMP = 7, K_JAL = 8, K_JPR = 9, K_JRL = 10, K_WWD = 11, K_HLT = 12, K_UND = 13;
   localparam int P_FETCH = 0, P_ID = 1, P_EX = 2, P_MEM = 3, P_WB = 4, P_HALT = 5;

   function automatic int kindOf(input logic [15:0] ir);
      int r;
      r = K_UND;
      if (ir[15:12] <= 4'd3) r = K_BR;
      else if (ir[15:12] == 4'd4) r = K_ADI;
      else if (ir[15:12] == 4'd5) r = K_ORI;
      else if (ir[15:12] == 4'd6) r = K_LHI;
      else if (ir[15:12] == 4'd7) r = K_LWD;
      else if (ir[15:12] == 4'd8) r = K_SWD;
      else if (ir[15:12] == 4'd9) r = K_JMP;
      else if (ir[15:12] == 4'd10) r = K_JAL;
      else if (ir[15:12] == 4'd15) begin
         if (ir[5:0] < 6'd8) r = K_RALU;
         else if (ir[5:0] == 6'd25) r = K_JPR;
         else if (ir[5:0] == 6'd26) r = K_JRL;
         else if (ir[5:0] == 6'd28) r = K_WWD;
         else if (ir[5:0] == 6'd29) r = K_HLT;
      end
      return r;
   endfunction

   logic [15:0] mIr;
   logic [15:0] mCount;
   bit          mFetching, mHalted, mMemDone, modelValid;
   int          mAge;

   // Phase follows from how long the instruction has been decoded and whether memory answered.
   function automatic int phaseNow();
      int k, r;
      k = kindOf(mIr);
      if (mHalted) r = P_HALT;
      else if (mFetching) r = P_FETCH;
      else if (mAge == 1) r = P_ID;
      else if (k == K_JMP || k == K_JAL || k == K_JPR || k == K_JRL || k == K_WWD || k == K_UND) r = P_WB;
      else if (mAge == 2) r = P_EX;
      else if (k == K_LWD || k == K_SWD) r = mMemDone ? P_WB : P_MEM;
      else r = P_WB;
      return r;
   endfunction

   always @(posedge clk) begin
      int ph;
      cycleCount++;
      if (reset) begin
         mIr = 16'h0; mCount = 16'h0; mFetching = 1'b1; mHalted = 1'b0;
         mMemDone = 1'b0; mAge = 0; modelValid = 1'b1;
      end else if (modelValid) begin
         ph = phaseNow();
         if (ph == P_FETCH) begin
            if (inst_ack) begin
               mIr = inst_data; mFetching = 1'b0; mAge = 1; mMemDone = 1'b0;
            end
         end else if (ph == P_ID) begin
            if (kindOf(mIr) == K_HLT) mHalted = 1'b1;
            mAge++;
         end else if (ph == P_EX) begin
            mAge++;
         end else if (ph == P_MEM) begin
            if (mem_ack) mMemDone = 1'b1;
         end else if (ph == P_WB) begin
            mCount = mCount + 16'd1;
            mFetching = 1'b1;
         end
      end
   end

   // Every cycle after the first reset edge, all outputs must agree with the model.
   always @(negedge clk) begin
      int ph, k;
      bit expWrite;
      logic [1:0] expDest, expSrc;
      if (mem_req) memReqCycles++;
      if (mem_req && mem_we) memWeCycles++;
      if (modelValid) begin
         ph = phaseNow();
         k = kindOf(mIr);
         expWrite = (ph == P_WB) && (k == K_RALU || k == K_ADI || k == K_ORI || k == K_LHI ||
                                     k == K_LWD || k == K_JAL || k == K_JRL);
         expDest = (k == K_RALU) ? mIr[7:6] : ((k == K_JAL || k == K_JRL) ? 2'd2 : mIr[9:8]);
         expSrc = (k == K_LWD) ? 2'd1 : ((k == K_JAL || k == K_JRL) ? 2'd2 : 2'd0);
         checkOutput("inst_req", inst_req, ph == P_FETCH);
         checkOutput("mem_req", mem_req, ph == P_MEM);
         if (ph == P_MEM) checkOutput("mem_we", mem_we, k == K_SWD);
         checkOutput("PVSWriteEn", PVSWriteEn, ph == P_WB);
         checkOutput("RegWrite", RegWrite, expWrite);
         if (expWrite) begin
            checkOutput("writeReg", writeReg, expDest);
            checkOutput("wb_src", wb_src, expSrc);
         end
         checkOutput("out_valid", out_valid, (ph == P_WB) && (k == K_WWD));
         checkOutput("halted", halted, ph == P_HALT);
         checkOutput("num_inst", num_inst, mCount);
         checkOutput("readReg1", readReg1, mIr[11:10]);
         checkOutput("readReg2", readReg2, mIr[9:8]);
         if (ph == P_EX) begin
            if (k == K_RALU) begin
               checkOutput("alu_op", alu_op, mIr[3:0]);
               checkOutput("alu_src_imm", alu_src_imm, 0);
            end else if (k == K_BR) begin
               checkOutput("alu_op", alu_op, 1);
               checkOutput("alu_src_imm", alu_src_imm, 0);
            end else if (k == K_ORI || k == K_LHI) begin
               checkOutput("alu_src_imm", alu_src_imm, 1);
            end else begin
               checkOutput("alu_op", alu_op, 0);
               checkOutput("alu_src_imm", alu_src_imm, 1);
            end
         end
      end
   end

   task automatic stepCycle();
      @(posedge clk);
      #2;
   endtask

   task automatic serveFetch(input logic [15:0] data, input int waitCycles);
      int guard;
      guard = 0;
      while (!inst_req && guard < 50) begin
         stepCycle();
         guard++;
      end
      checkOutput("fetchReqSeen", inst_req, 1);
      repeat (waitCycles) stepCycle();
      inst_data = data;
      inst_ack = 1'b1;
      stepCycle();
      inst_ack = 1'b0;
      inst_data = 16'h0;
   endtask

   // Runs one instruction from fetch until its WB (or HALT) cycle; returns cycles spent after ID.
   task automatic applyStimulus(input logic [15:0] data, input int fetchWait, input int memWait,
                                input bit spurious, output int cyclesToEnd);
      int memSeen;
      memSeen = 0;
      cyclesToEnd = -1;
      serveFetch(data, fetchWait);
      for (int i = 0; i < 40; i++) begin
         if (PVSWriteEn || halted) begin
            cyclesToEnd = i;
            break;
         end
         if (mem_req) begin
            mem_ack = (memSeen == memWait);
            memSeen++;
         end else begin
            mem_ack = spurious;
         end
         inst_ack = spurious;
         inst_data = spurious ? 16'hFFFF : 16'h0;
         stepCycle();
      end
      mem_ack = 1'b0;
      inst_ack = 1'b0;
      inst_data = 16'h0;
      checkOutput("endReached", cyclesToEnd >= 0, 1);
   endtask

   logic [15:0] extraInst [11] = '{16'h4A7F, 16'h5B01, 16'h6312, 16'h1600, 16'hF9C1, 16'hF247,
                                   16'h9010, 16'hF019, 16'hF01A, 16'hB000, 16'hF01E};
   int          extraCyc  [11] = '{2, 2, 2, 2, 2, 2, 1, 1, 1, 1, 1};

   initial begin
      int cyc, releaseCyc;
      reset = 1'b1; inst_ack = 1'b0; mem_ack = 1'b0; inst_data = 16'h0;
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
      releaseCyc = cycleCount;
      checkOutput("rstInstReq", inst_req, 1);
      checkOutput("rstNumInst", num_inst, 0);
      checkOutput("rstMemReq", mem_req, 0);
      checkOutput("rstPVS", PVSWriteEn, 0);
      checkOutput("rstRegWrite", RegWrite, 0);
      checkOutput("rstWriteReg", writeReg, 0);
      checkOutput("rstReadReg1", readReg1, 0);
      checkOutput("rstAluOp", alu_op, 0);
      checkOutput("rstWbSrc", wb_src, 0);
      checkOutput("rstHalted", halted, 0);

      applyStimulus(16'hF6C0, 2, 0, 1'b0, cyc);
      checkOutput("addLatency", cyc, 2);
      checkOutput("addWbCycle", cycleCount - releaseCyc, 5);
      checkOutput("addWriteReg", writeReg, 3);
      checkOutput("addRegWrite", RegWrite, 1);
      checkOutput("addPVS", PVSWriteEn, 1);
      stepCycle();
      checkOutput("addNumInst", num_inst, 1);
      checkOutput("modelCount", mCount, 1);
      checkOutput("pvsNotRepeated", PVSWriteEn, 0);

      memReqCycles = 0;
      applyStimulus(16'h7200, 0, 3, 1'b0, cyc);
      checkOutput("lwdLatency", cyc, 6);
      checkOutput("lwdMemReqCycles", memReqCycles, 4);
      checkOutput("lwdWbSrc", wb_src, 1);
      checkOutput("lwdWriteReg", writeReg, 2);
      checkOutput("lwdRegWrite", RegWrite, 1);
      stepCycle();

      memWeCycles = 0;
      applyStimulus(16'h8100, 1, 0, 1'b1, cyc);
      checkOutput("swdLatency", cyc, 3);
      checkOutput("swdMemWeCycles", memWeCycles, 1);
      checkOutput("swdPVS", PVSWriteEn, 1);
      checkOutput("swdRegWrite", RegWrite, 0);
      stepCycle();
      checkOutput("swdNumInst", num_inst, 3);

      applyStimulus(16'hA005, 0, 0, 1'b0, cyc);
      checkOutput("jalLatency", cyc, 1);
      checkOutput("jalWriteReg", writeReg, 2);
      checkOutput("jalWbSrc", wb_src, 2);
      checkOutput("jalRegWrite", RegWrite, 1);
      stepCycle();

      applyStimulus(16'hF01C, 0, 0, 1'b1, cyc);
      checkOutput("wwdLatency", cyc, 1);
      checkOutput("wwdOutValid", out_valid, 1);
      checkOutput("wwdRegWrite", RegWrite, 0);
      stepCycle();
      checkOutput("wwdOutValidDrop", out_valid, 0);
      checkOutput("wwdNumInst", num_inst, 5);

      for (int i = 0; i < 11; i++) begin
         applyStimulus(extraInst[i], i % 3, 0, i[0], cyc);
         checkOutput("extraLatency", cyc, extraCyc[i]);
         stepCycle();
      end
      checkOutput("extraNumInst", num_inst, 16);

      applyStimulus(16'hF01D, 0, 0, 1'b0, cyc);
      checkOutput("hltLatency", cyc, 1);
      checkOutput("hltHalted", halted, 1);
      for (int i = 0; i < 3; i++) begin
         inst_ack = 1'b1;
         inst_data = 16'hF6C0;
         stepCycle();
         inst_ack = 1'b0;
         checkOutput("hltInstReq", inst_req, 0);
         checkOutput("hltPVS", PVSWriteEn, 0);
         checkOutput("hltNumInst", num_inst, 16);
         stepCycle();
      end

      reset = 1'b1;
      stepCycle();
      reset = 1'b0;
      serveFetch(16'h7200, 0);
      stepCycle();
      stepCycle();
      checkOutput("midMemReq", mem_req, 1);
      reset = 1'b1;
      mem_ack = 1'b1;
      stepCycle();
      reset = 1'b0;
      mem_ack = 1'b0;
      checkOutput("rstMemInstReq", inst_req, 1);
      checkOutput("rstMemNumInst", num_inst, 0);
      checkOutput("rstMemPVS", PVSWriteEn, 0);
      checkOutput("rstMemMemReq", mem_req, 0);
      for (int i = 0; i < 3; i++) begin
         stepCycle();
         checkOutput("rstMemNoWb", PVSWriteEn, 0);
         checkOutput("rstMemHoldReq", inst_req, 1);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
